// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage data memory access unit with single-outstanding bus handshake
//
// Purpose: turns a MEM-stage load/store into one request on a ready-terminated
// data bus. It does the lane mapping for stores and the alignment and extension
// for loads, stalls the pipeline while the transfer is outstanding, and flags
// misaligned accesses instead of issuing them.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   MEM_MemRead/Write     load / store present (both high = store)
//   MEM_MemByte/Half      access size (neither = word)
//   MEM_MemSignExt        sign-extend byte/half loads
//   MEM_Flush             discard the current access
//   MEM_ALU_Result        byte address
//   MEM_ReadData2         store data (low bits)
//   DataMem_Ready/RData   bus completion and read word
//   DataMem_Req/Write/Addr/WData/BE  registered bus request
//   MEM_ReadData          load result, valid in DONE only
//   MEM_Stall             hold MEM and upstream stages
//   MEM_ExcAdEL/AdES      misaligned load / store
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemByte,
  input  logic        MEM_MemHalf,
  input  logic        MEM_MemSignExt,
  input  logic        MEM_Flush,
  input  logic [31:0] MEM_ALU_Result,
  input  logic [31:0] MEM_ReadData2,
  input  logic        DataMem_Ready,
  input  logic [31:0] DataMem_RData,
  output logic        DataMem_Req,
  output logic        DataMem_Write,
  output logic [31:0] DataMem_Addr,
  output logic [31:0] DataMem_WData,
  output logic [3:0]  DataMem_BE,
  output logic [31:0] MEM_ReadData,
  output logic        MEM_Stall,
  output logic        MEM_ExcAdEL,
  output logic        MEM_ExcAdES
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  off;
  logic        valid;
  logic        is_store;
  logic        misaligned;
  logic        aligned_valid;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // Access attributes latched at issue so the load can be shaped on completion
  // even after the pipeline inputs have moved on.
  logic [1:0]  off_q;
  logic        byte_q;
  logic        half_q;
  logic        sext_q;
  logic        flushed_q;
  logic [31:0] load_q;
  logic [31:0] lane;
  logic [31:0] load_next;

  assign off           = MEM_ALU_Result[1:0];
  assign valid         = (MEM_MemRead | MEM_MemWrite) & ~MEM_Flush;
  assign is_store      = MEM_MemWrite;
  assign aligned_valid = valid & ~misaligned;

  always_comb begin
    misaligned = 1'b0;
    if (MEM_MemByte)      misaligned = 1'b0;
    else if (MEM_MemHalf) misaligned = off[0];
    else                  misaligned = |off;
  end

  // Gated by rst so the combinational outputs also read 0 while in reset.
  assign MEM_Stall   = rst & ((state == BUSY) | (aligned_valid & (state != DONE)));
  assign MEM_ExcAdEL = rst & valid & misaligned & ~is_store;
  assign MEM_ExcAdES = rst & valid & misaligned & is_store;

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = MEM_ReadData2;
    if (MEM_MemByte) begin
      be_next    = 4'b0001 << off;
      wdata_next = {4{MEM_ReadData2[7:0]}};
    end else if (MEM_MemHalf) begin
      be_next    = 4'b0011 << off;
      wdata_next = {2{MEM_ReadData2[15:0]}};
    end
  end

  assign lane = DataMem_RData >> {off_q, 3'b000};

  always_comb begin
    load_next = DataMem_RData;
    if (byte_q)      load_next = {{24{sext_q & lane[7]}}, lane[7:0]};
    else if (half_q) load_next = {{16{sext_q & lane[15]}}, lane[15:0]};
  end

  assign MEM_ReadData = (state == DONE) ? load_q : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      DataMem_Req   <= 1'b0;
      DataMem_Write <= 1'b0;
      DataMem_Addr  <= 32'd0;
      DataMem_WData <= 32'd0;
      DataMem_BE    <= 4'd0;
      off_q         <= 2'd0;
      byte_q        <= 1'b0;
      half_q        <= 1'b0;
      sext_q        <= 1'b0;
      flushed_q     <= 1'b0;
      load_q        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (aligned_valid) begin
            state         <= BUSY;
            DataMem_Req   <= 1'b1;
            DataMem_Write <= is_store;
            DataMem_Addr  <= {MEM_ALU_Result[31:2], 2'b00};
            DataMem_WData <= wdata_next;
            DataMem_BE    <= be_next;
            off_q         <= off;
            byte_q        <= MEM_MemByte;
            half_q        <= ~MEM_MemByte & MEM_MemHalf;
            sext_q        <= MEM_MemSignExt;
            flushed_q     <= 1'b0;
          end
        end
        BUSY: begin
          // A flush cannot abort the bus, so remember it until completion.
          if (MEM_Flush) flushed_q <= 1'b1;
          if (DataMem_Ready) begin
            DataMem_Req <= 1'b0;
            if (flushed_q | MEM_Flush) begin
              state  <= IDLE;
              load_q <= 32'd0;
            end else begin
              state  <= DONE;
              load_q <= DataMem_Write ? 32'd0 : load_next;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          load_q <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        MEM_MemRead, MEM_MemWrite, MEM_MemByte, MEM_MemHalf, MEM_MemSignExt, MEM_Flush;
  logic [31:0] MEM_ALU_Result, MEM_ReadData2;
  logic        DataMem_Ready;
  logic [31:0] DataMem_RData;
  logic        DataMem_Req, DataMem_Write;
  logic [31:0] DataMem_Addr, DataMem_WData;
  logic [3:0]  DataMem_BE;
  logic [31:0] MEM_ReadData;
  logic        MEM_Stall, MEM_ExcAdEL, MEM_ExcAdES;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access dut (
    .clk(clk), .rst(rst),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_MemByte(MEM_MemByte), .MEM_MemHalf(MEM_MemHalf),
    .MEM_MemSignExt(MEM_MemSignExt), .MEM_Flush(MEM_Flush),
    .MEM_ALU_Result(MEM_ALU_Result), .MEM_ReadData2(MEM_ReadData2),
    .DataMem_Ready(DataMem_Ready), .DataMem_RData(DataMem_RData),
    .DataMem_Req(DataMem_Req), .DataMem_Write(DataMem_Write),
    .DataMem_Addr(DataMem_Addr), .DataMem_WData(DataMem_WData),
    .DataMem_BE(DataMem_BE), .MEM_ReadData(MEM_ReadData),
    .MEM_Stall(MEM_Stall), .MEM_ExcAdEL(MEM_ExcAdEL), .MEM_ExcAdES(MEM_ExcAdES)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    MEM_MemRead = 0; MEM_MemWrite = 0; MEM_MemByte = 0; MEM_MemHalf = 0;
    MEM_MemSignExt = 0; MEM_Flush = 0; MEM_ALU_Result = 0; MEM_ReadData2 = 0;
    DataMem_Ready = 0; DataMem_RData = 0;
  endtask

  // Presents one access and plays the bus: Ready rises in BUSY cycle `delay`,
  // Flush rises in BUSY cycle `flush_at` (-1 = never). Returns in the cycle
  // after Req falls, with the access inputs still applied.
  task automatic do_access(
    input logic rd, input logic wr, input logic byt, input logic hlf, input logic sx,
    input int flush_at, input int delay,
    input logic [31:0] addr, input logic [31:0] d, input logic [31:0] rdata,
    output int stall_n, output int req_n, output logic [31:0] rdv,
    output logic [31:0] a_seen, output logic [31:0] wd_seen, output logic [3:0] be_seen,
    output logic wr_seen, output logic timeout);
    logic prev_req;
    int   busy_k;
    stall_n = 0; req_n = 0; rdv = 32'hxxxx_xxxx; timeout = 1;
    a_seen = 0; wd_seen = 0; be_seen = 0; wr_seen = 0;
    prev_req = 0; busy_k = 0;
    MEM_MemRead = rd; MEM_MemWrite = wr; MEM_MemByte = byt; MEM_MemHalf = hlf;
    MEM_MemSignExt = sx; MEM_Flush = 0; MEM_ALU_Result = addr; MEM_ReadData2 = d;
    DataMem_RData = rdata; DataMem_Ready = 0;
    for (int k = 0; k < 40; k++) begin
      if (prev_req && !DataMem_Req) begin
        DataMem_Ready = 0;
        #1;
        rdv = MEM_ReadData;
        if (MEM_Stall) stall_n++;
        timeout = 0;
        break;
      end
      if (DataMem_Req) begin
        req_n++;
        a_seen = DataMem_Addr; wd_seen = DataMem_WData; be_seen = DataMem_BE; wr_seen = DataMem_Write;
        DataMem_Ready = (busy_k == delay);
        if (busy_k == flush_at) MEM_Flush = 1;
        busy_k++;
      end else begin
        DataMem_Ready = 0;
      end
      #1;
      if (MEM_Stall) stall_n++;
      prev_req = DataMem_Req;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    MEM_MemRead = 1; MEM_ALU_Result = 32'h40;
    @(posedge clk); #1; @(posedge clk); #1;
    n_cmp++; if (DataMem_Req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", DataMem_Req); end
    n_cmp++; if (DataMem_Write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %b want 0", DataMem_Write); end
    n_cmp++; if (DataMem_Addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", DataMem_Addr); end
    n_cmp++; if (DataMem_WData !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", DataMem_WData); end
    n_cmp++; if (DataMem_BE !== 4'd0) begin n_bad++; $display("FAIL reset_be: got %b want 0", DataMem_BE); end
    n_cmp++; if (MEM_ReadData !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", MEM_ReadData); end
    n_cmp++; if (MEM_Stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", MEM_Stall); end
    MEM_MemWrite = 1; MEM_ALU_Result = 32'h41; #1;
    n_cmp++; if ({MEM_ExcAdEL, MEM_ExcAdES} !== 2'b00) begin n_bad++; $display("FAIL reset_exc: got %b want 00", {MEM_ExcAdEL, MEM_ExcAdES}); end
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_signed_load();
    int s, r; logic [31:0] rdv, a, wd; logic [3:0] be; logic w, to;
    do_access(1, 0, 1, 0, 1, -1, 0, 32'h103, 32'h0, 32'h80FF_1234, s, r, rdv, a, wd, be, w, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL bload_timeout: got %b want 0", to); end
    n_cmp++; if (a !== 32'h100) begin n_bad++; $display("FAIL bload_addr: got %h want 00000100", a); end
    n_cmp++; if (be !== 4'b1000) begin n_bad++; $display("FAIL bload_be: got %b want 1000", be); end
    n_cmp++; if (w !== 1'b0) begin n_bad++; $display("FAIL bload_write: got %b want 0", w); end
    n_cmp++; if (s != 2) begin n_bad++; $display("FAIL bload_stall_cycles: got %0d want 2", s); end
    n_cmp++; if (r != 1) begin n_bad++; $display("FAIL bload_req_cycles: got %0d want 1", r); end
    n_cmp++; if (rdv !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL bload_rdata: got %h want ffffff80", rdv); end
    idle_inputs();
    @(posedge clk); #1;
    n_cmp++; if (MEM_ReadData !== 32'd0) begin n_bad++; $display("FAIL bload_rdata_idle: got %h want 0", MEM_ReadData); end
  endtask

  task automatic test_half_store();
    int s, r; logic [31:0] rdv, a, wd; logic [3:0] be; logic w, to;
    do_access(0, 1, 0, 1, 0, -1, 3, 32'h202, 32'hABCD_5678, 32'hFFFF_FFFF, s, r, rdv, a, wd, be, w, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL hstore_timeout: got %b want 0", to); end
    n_cmp++; if (wd !== 32'h5678_5678) begin n_bad++; $display("FAIL hstore_wdata: got %h want 56785678", wd); end
    n_cmp++; if (be !== 4'b1100) begin n_bad++; $display("FAIL hstore_be: got %b want 1100", be); end
    n_cmp++; if (a !== 32'h200) begin n_bad++; $display("FAIL hstore_addr: got %h want 00000200", a); end
    n_cmp++; if (w !== 1'b1) begin n_bad++; $display("FAIL hstore_write: got %b want 1", w); end
    n_cmp++; if (r != 4) begin n_bad++; $display("FAIL hstore_req_cycles: got %0d want 4", r); end
    n_cmp++; if (s != 5) begin n_bad++; $display("FAIL hstore_stall_cycles: got %0d want 5", s); end
    n_cmp++; if (rdv !== 32'd0) begin n_bad++; $display("FAIL hstore_rdata: got %h want 0", rdv); end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    idle_inputs();
    MEM_MemRead = 1; MEM_ALU_Result = 32'h301; #1;
    n_cmp++; if (MEM_ExcAdEL !== 1'b1) begin n_bad++; $display("FAIL misw_adel: got %b want 1", MEM_ExcAdEL); end
    n_cmp++; if (MEM_ExcAdES !== 1'b0) begin n_bad++; $display("FAIL misw_ades: got %b want 0", MEM_ExcAdES); end
    n_cmp++; if (MEM_Stall !== 1'b0) begin n_bad++; $display("FAIL misw_stall: got %b want 0", MEM_Stall); end
    @(posedge clk); #1; @(posedge clk); #1;
    n_cmp++; if (DataMem_Req !== 1'b0) begin n_bad++; $display("FAIL misw_req: got %b want 0", DataMem_Req); end
    MEM_MemRead = 0; MEM_MemWrite = 1; MEM_MemHalf = 1; MEM_ALU_Result = 32'h205; #1;
    n_cmp++; if ({MEM_ExcAdEL, MEM_ExcAdES} !== 2'b01) begin n_bad++; $display("FAIL mish_exc: got %b want 01", {MEM_ExcAdEL, MEM_ExcAdES}); end
    MEM_MemByte = 1; MEM_MemHalf = 0; MEM_ALU_Result = 32'h203; #1;
    n_cmp++; if ({MEM_ExcAdES, MEM_Stall} !== 2'b01) begin n_bad++; $display("FAIL byte_never_mis: got %b want 01", {MEM_ExcAdES, MEM_Stall}); end
    MEM_MemWrite = 0;
    idle_inputs();
    @(posedge clk); #1;
    n_cmp++; if (DataMem_Req !== 1'b0) begin n_bad++; $display("FAIL mis_req_after: got %b want 0", DataMem_Req); end
  endtask

  task automatic test_unsigned_half_load();
    int s, r; logic [31:0] rdv, a, wd; logic [3:0] be; logic w, to;
    do_access(1, 0, 0, 1, 0, -1, 1, 32'h0, 32'h0, 32'h1234_F00D, s, r, rdv, a, wd, be, w, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL uhload_timeout: got %b want 0", to); end
    n_cmp++; if (rdv !== 32'h0000_F00D) begin n_bad++; $display("FAIL uhload_rdata: got %h want 0000f00d", rdv); end
    n_cmp++; if (be !== 4'b0011) begin n_bad++; $display("FAIL uhload_be: got %b want 0011", be); end
    n_cmp++; if (s != 3) begin n_bad++; $display("FAIL uhload_stall_cycles: got %0d want 3", s); end
    n_cmp++; if (r != 2) begin n_bad++; $display("FAIL uhload_req_cycles: got %0d want 2", r); end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_flush_busy();
    int s, r; logic [31:0] rdv, a, wd; logic [3:0] be; logic w, to;
    do_access(1, 0, 0, 0, 0, 0, 2, 32'h400, 32'h0, 32'h1122_3344, s, r, rdv, a, wd, be, w, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL flush_timeout: got %b want 0", to); end
    n_cmp++; if (r != 3) begin n_bad++; $display("FAIL flush_req_cycles: got %0d want 3", r); end
    n_cmp++; if (s != 4) begin n_bad++; $display("FAIL flush_stall_cycles: got %0d want 4", s); end
    n_cmp++; if (rdv !== 32'd0) begin n_bad++; $display("FAIL flush_rdata: got %h want 0", rdv); end
    // In IDLE a fresh aligned access stalls at once; in DONE it would not.
    MEM_Flush = 0; #1;
    n_cmp++; if (MEM_Stall !== 1'b1) begin n_bad++; $display("FAIL flush_no_done: got stall %b want 1", MEM_Stall); end
    idle_inputs(); #1;
    @(posedge clk); #1;
    n_cmp++; if (DataMem_Req !== 1'b0) begin n_bad++; $display("FAIL flush_req_after: got %b want 0", DataMem_Req); end
  endtask

  task automatic test_reset_busy();
    int s, r; logic [31:0] rdv, a, wd; logic [3:0] be; logic w, to;
    idle_inputs();
    MEM_MemRead = 1; MEM_ALU_Result = 32'h8; DataMem_RData = 32'h5555_5555;
    @(posedge clk); #1;
    n_cmp++; if (DataMem_Req !== 1'b1) begin n_bad++; $display("FAIL rstb_req_before: got %b want 1", DataMem_Req); end
    #2 rst = 0; #1;
    n_cmp++; if (DataMem_Req !== 1'b0) begin n_bad++; $display("FAIL rstb_req_drop: got %b want 0", DataMem_Req); end
    n_cmp++; if ({MEM_Stall, DataMem_Addr} !== 33'd0) begin n_bad++; $display("FAIL rstb_clear: got %h want 0", {MEM_Stall, DataMem_Addr}); end
    idle_inputs(); #1 rst = 1;
    @(posedge clk); #1;
    n_cmp++; if (DataMem_Req !== 1'b0) begin n_bad++; $display("FAIL rstb_idle: got %b want 0", DataMem_Req); end
    do_access(1, 0, 0, 0, 0, -1, 1, 32'h8, 32'h0, 32'hDEAD_BEEF, s, r, rdv, a, wd, be, w, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rstb_timeout: got %b want 0", to); end
    n_cmp++; if (rdv !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rstb_rdata: got %h want deadbeef", rdv); end
    n_cmp++; if (s != 3) begin n_bad++; $display("FAIL rstb_stall_cycles: got %0d want 3", s); end
    n_cmp++; if (a !== 32'h8) begin n_bad++; $display("FAIL rstb_addr: got %h want 00000008", a); end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int s, r; logic [31:0] rdv, a, wd; logic [3:0] be; logic w, to;
    do_access(0, 1, 1, 0, 0, -1, 0, 32'h001, 32'h1234_56A5, 32'h0, s, r, rdv, a, wd, be, w, to);
    n_cmp++; if (wd !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL b2b_wdata: got %h want a5a5a5a5", wd); end
    n_cmp++; if (be !== 4'b0010) begin n_bad++; $display("FAIL b2b_be: got %b want 0010", be); end
    n_cmp++; if (rdv !== 32'd0) begin n_bad++; $display("FAIL b2b_store_rdata: got %h want 0", rdv); end
    // Next access presented straight from the DONE cycle.
    do_access(1, 1'b0, 0, 0, 1, -1, 0, 32'h10, 32'h0, 32'h8000_0001, s, r, rdv, a, wd, be, w, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: got %b want 0", to); end
    n_cmp++; if (rdv !== 32'h8000_0001) begin n_bad++; $display("FAIL b2b_word_rdata: got %h want 80000001", rdv); end
    n_cmp++; if ({be, a} !== {4'b1111, 32'h10}) begin n_bad++; $display("FAIL b2b_be_addr: got %h want f00000010", {be, a}); end
    n_cmp++; if (s != 2 || r != 1) begin n_bad++; $display("FAIL b2b_cycles: got stall %0d req %0d want 2 1", s, r); end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_byte_signed_load();
    test_half_store();
    test_misaligned();
    test_unsigned_half_load();
    test_flush_busy();
    test_reset_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
